// File: rtl/rvv_inst_pkg.sv
// Shared types for the RVV instruction front end: opcode/funct3 encodings,
// the vtype CSR layout and the predecoded FIFO entry.
package rvv_inst_pkg;

    typedef enum logic [6:0] {
        INST_LD  = 7'h07,
        INST_ST  = 7'h27,
        INST_ALU = 7'h57
    } inst_type_e;

    typedef enum logic [2:0] {
        OPIVV = 3'b000,
        OPFVV = 3'b001,
        OPMVV = 3'b010,
        OPIVI = 3'b011,
        OPIVX = 3'b100,
        OPFVF = 3'b101,
        OPMVX = 3'b110,
        OPCFG = 3'b111
    } alu_type_e;

    typedef struct packed {
        logic        vill;
        logic [22:0] reserved;
        logic        vma;
        logic        vta;
        logic [2:0]  vsew;
        logic [2:0]  vlmul;
    } vtype_t;

    localparam logic [1:0] ALU_CLASS_OPI = 2'b00;
    localparam logic [1:0] ALU_CLASS_OPM = 2'b01;
    localparam logic [7:0] ALU_INST_NONE = 8'hFF;

    typedef struct packed {
        inst_type_e  inst_type;
        alu_type_e   alu_type;
        logic [7:0]  alu_inst;
        logic [4:0]  vd;
        logic [4:0]  vs2;
        logic [4:0]  vs1;
        logic        vm;
        logic [31:0] inst;
    } predec_entry_t;

endpackage

// File: rtl/rvv_inst_predecode.sv
// Combinational classifier: splits a raw vector encoding into a predec_entry_t
// and flags encodings the backend cannot execute.
module rvv_inst_predecode
    import rvv_inst_pkg::*;
(
    input  logic [31:0]   i_inst,
    input  vtype_t        i_vtype,
    output predec_entry_t o_entry,
    output logic          o_illegal
);

    logic [6:0] w_opcode;
    alu_type_e  w_funct3;
    logic [5:0] w_funct6;
    logic       w_unused_vtype;

    assign w_opcode       = i_inst[6:0];
    assign w_funct3       = alu_type_e'(i_inst[14:12]);
    assign w_funct6       = i_inst[31:26];
    assign w_unused_vtype = ^i_vtype[30:0];

    always_comb begin
        o_entry           = '0;
        o_entry.inst_type = INST_ALU;
        o_entry.alu_type  = w_funct3;
        o_entry.alu_inst  = ALU_INST_NONE;
        o_entry.vd        = i_inst[11:7];
        o_entry.vs2       = i_inst[24:20];
        o_entry.vs1       = i_inst[19:15];
        o_entry.vm        = i_inst[25];
        o_entry.inst      = i_inst;
        o_illegal         = 1'b0;

        case (w_opcode)
            INST_LD: begin
                o_entry.inst_type = INST_LD;
                o_illegal         = i_vtype.vill;
            end
            INST_ST: begin
                o_entry.inst_type = INST_ST;
                o_illegal         = i_vtype.vill;
            end
            INST_ALU: begin
                o_entry.inst_type = INST_ALU;
                case (w_funct3)
                    OPIVV, OPIVI, OPIVX: o_entry.alu_inst = {ALU_CLASS_OPI, w_funct6};
                    OPMVV, OPMVX:        o_entry.alu_inst = {ALU_CLASS_OPM, w_funct6};
                    OPCFG:               o_entry.alu_inst = ALU_INST_NONE;
                    default:             o_illegal = 1'b1;
                endcase
                // vset* is what clears vill, so it must stay legal with vill set
                if (w_funct3 != OPCFG && i_vtype.vill) begin
                    o_illegal = 1'b1;
                end
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rvv_inst_predecode_fifo.sv
// RVV backend front end: predecodes incoming vector instructions, drops and
// counts illegal ones, and queues the rest for decode/dispatch.
module rvv_inst_predecode_fifo
    import rvv_inst_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned VLW   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [31:0]              i_in_inst,
    input  logic [XLEN-1:0]          i_in_rs1_data,
    input  logic [31:0]              i_in_vtype,
    input  logic [VLW-1:0]           i_in_vl,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [6:0]               o_out_inst_type,
    output logic [2:0]               o_out_alu_type,
    output logic [7:0]               o_out_alu_inst,
    output logic [4:0]               o_out_vd,
    output logic [4:0]               o_out_vs2,
    output logic [4:0]               o_out_vs1,
    output logic                     o_out_vm,
    output logic [31:0]              o_out_inst,
    output logic [XLEN-1:0]          o_out_rs1_data,
    output logic [31:0]              o_out_vtype,
    output logic [VLW-1:0]           o_out_vl,
    output logic                     o_illegal_pulse,
    output logic [7:0]               o_illegal_cnt,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    predec_entry_t   r_mem   [DEPTH];
    logic [XLEN-1:0] r_rs1   [DEPTH];
    logic [31:0]     r_vtype [DEPTH];
    logic [VLW-1:0]  r_vl    [DEPTH];

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_illegal_pulse;
    logic [7:0]      r_illegal_cnt;

    predec_entry_t   w_entry;
    predec_entry_t   w_head;
    logic            w_illegal;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_head_valid;

    rvv_inst_predecode u_predecode (
        .i_inst    (i_in_inst),
        .i_vtype   (vtype_t'(i_in_vtype)),
        .o_entry   (w_entry),
        .o_illegal (w_illegal)
    );

    // Both handshakes are masked during reset so nothing transfers in the flush cycle
    assign o_in_ready   = !i_rst && (r_count < (AW+1)'(DEPTH));
    assign w_head_valid = !i_rst && (r_count != '0);
    assign w_accept     = i_in_valid && o_in_ready;
    assign w_push       = w_accept && !w_illegal;
    assign w_pop        = w_head_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]   <= w_entry;
            r_rs1[r_wr_ptr]   <= i_in_rs1_data;
            r_vtype[r_wr_ptr] <= i_in_vtype;
            r_vl[r_wr_ptr]    <= i_in_vl;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_illegal_pulse <= 1'b0;
            r_illegal_cnt   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            r_illegal_pulse <= w_accept && w_illegal;
            if (w_accept && w_illegal && r_illegal_cnt != 8'hFF) begin
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        o_out_inst_type = '0;
        o_out_alu_type  = '0;
        o_out_alu_inst  = '0;
        o_out_vd        = '0;
        o_out_vs2       = '0;
        o_out_vs1       = '0;
        o_out_vm        = 1'b0;
        o_out_inst      = '0;
        o_out_rs1_data  = '0;
        o_out_vtype     = '0;
        o_out_vl        = '0;
        if (w_head_valid) begin
            o_out_inst_type = w_head.inst_type;
            o_out_alu_type  = w_head.alu_type;
            o_out_alu_inst  = w_head.alu_inst;
            o_out_vd        = w_head.vd;
            o_out_vs2       = w_head.vs2;
            o_out_vs1       = w_head.vs1;
            o_out_vm        = w_head.vm;
            o_out_inst      = w_head.inst;
            o_out_rs1_data  = r_rs1[r_rd_ptr];
            o_out_vtype     = r_vtype[r_rd_ptr];
            o_out_vl        = r_vl[r_rd_ptr];
        end
    end

    assign o_out_valid     = w_head_valid;
    assign o_illegal_pulse = r_illegal_pulse;
    assign o_illegal_cnt   = r_illegal_cnt;
    assign o_count         = r_count;

endmodule

// File: tb/tb_rvv_inst_predecode_fifo.sv
// Directed bench for rvv_inst_predecode_fifo: decode fields, illegal drop and
// saturation, full/back-pressure ordering and mid-operation reset.
module tb_rvv_inst_predecode_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rs1_data;
    logic [31:0] in_vtype;
    logic [7:0]  in_vl;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_inst_type;
    logic [2:0]  out_alu_type;
    logic [7:0]  out_alu_inst;
    logic [4:0]  out_vd;
    logic [4:0]  out_vs2;
    logic [4:0]  out_vs1;
    logic        out_vm;
    logic [31:0] out_inst;
    logic [31:0] out_rs1_data;
    logic [31:0] out_vtype;
    logic [7:0]  out_vl;
    logic        illegal_pulse;
    logic [7:0]  illegal_cnt;
    logic [2:0]  count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    rvv_inst_predecode_fifo #(.DEPTH(4), .XLEN(32), .VLW(8)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_in_valid      (in_valid),
        .o_in_ready      (in_ready),
        .i_in_inst       (in_inst),
        .i_in_rs1_data   (in_rs1_data),
        .i_in_vtype      (in_vtype),
        .i_in_vl         (in_vl),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_inst_type (out_inst_type),
        .o_out_alu_type  (out_alu_type),
        .o_out_alu_inst  (out_alu_inst),
        .o_out_vd        (out_vd),
        .o_out_vs2       (out_vs2),
        .o_out_vs1       (out_vs1),
        .o_out_vm        (out_vm),
        .o_out_inst      (out_inst),
        .o_out_rs1_data  (out_rs1_data),
        .o_out_vtype     (out_vtype),
        .o_out_vl        (out_vl),
        .o_illegal_pulse (illegal_pulse),
        .o_illegal_cnt   (illegal_cnt),
        .o_count         (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] rs1,
                         input logic [31:0] vt);
        in_valid    = v;
        in_inst     = inst;
        in_rs1_data = rs1;
        in_vtype    = vt;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        in_vl = 8'h10;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        check("rst_illegal_pulse", 32'(illegal_pulse), 32'd0);
        check("rst_alu_inst", 32'(out_alu_inst), 32'd0);

        // vadd.vv v3,v2,v1
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h022081D7, 32'h0, 32'h0000_0012);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("empty_no_bypass", 32'(out_valid), 32'd0);
        tick();
        // vmul.vx v8,v4,x5 offered while vadd is at the head and being popped
        drive(1'b1, 32'h9642E457, 32'h1234, 32'h0);
        check("vadd_valid", 32'(out_valid), 32'd1);
        check("vadd_inst_type", 32'(out_inst_type), 32'h57);
        check("vadd_alu_inst", 32'(out_alu_inst), 32'h00);
        check("vadd_alu_type", 32'(out_alu_type), 32'd0);
        check("vadd_vd", 32'(out_vd), 32'd3);
        check("vadd_vs2", 32'(out_vs2), 32'd2);
        check("vadd_vs1", 32'(out_vs1), 32'd1);
        check("vadd_vm", 32'(out_vm), 32'd1);
        check("vadd_vtype", out_vtype, 32'h0000_0012);
        check("vadd_vl", 32'(out_vl), 32'h10);
        tick();
        drive(1'b1, 32'h02006007, 32'h0, 32'h0);
        check("vmul_count", 32'(count), 32'd1);
        check("vmul_alu_inst", 32'(out_alu_inst), 32'h65);
        check("vmul_alu_type", 32'(out_alu_type), 32'd6);
        check("vmul_vd", 32'(out_vd), 32'd8);
        check("vmul_vs2", 32'(out_vs2), 32'd4);
        check("vmul_vs1", 32'(out_vs1), 32'd5);
        check("vmul_rs1", out_rs1_data, 32'h1234);
        check("vmul_inst", out_inst, 32'h9642E457);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("vle_inst_type", 32'(out_inst_type), 32'h07);
        check("vle_alu_type", 32'(out_alu_type), 32'd6);
        check("vle_alu_inst", 32'(out_alu_inst), 32'hFF);
        tick();
        check("drained_count", 32'(count), 32'd0);
        check("drained_valid", 32'(out_valid), 32'd0);

        // OPFVV: accepted, dropped, counted
        drive(1'b1, 32'h00001057, 32'h0, 32'h0);
        #1;
        check("illegal_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("opf_pulse", 32'(illegal_pulse), 32'd1);
        check("opf_cnt", 32'(illegal_cnt), 32'd1);
        check("opf_no_out", 32'(out_valid), 32'd0);
        check("opf_count", 32'(count), 32'd0);
        tick();
        check("opf_pulse_clear", 32'(illegal_pulse), 32'd0);

        // vadd with vill set is illegal; vsetvli-type OPCFG with vill set is legal
        drive(1'b1, 32'h022081D7, 32'h0, 32'h8000_0000);
        tick();
        drive(1'b1, 32'h00007057, 32'h0, 32'h8000_0000);
        check("vill_alu_cnt", 32'(illegal_cnt), 32'd2);
        check("vill_alu_no_out", 32'(out_valid), 32'd0);
        tick();
        drive(1'b1, 32'h00000033, 32'h0, 32'h0);
        check("opcfg_valid", 32'(out_valid), 32'd1);
        check("opcfg_alu_inst", 32'(out_alu_inst), 32'hFF);
        check("opcfg_alu_type", 32'(out_alu_type), 32'd7);
        check("opcfg_cnt", 32'(illegal_cnt), 32'd2);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("bad_opcode_cnt", 32'(illegal_cnt), 32'd3);
        check("bad_opcode_no_out", 32'(out_valid), 32'd0);

        // 300 back-to-back illegal instructions: pulse stays high, count saturates
        drive(1'b1, 32'h00001057, 32'h0, 32'h0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 2) check("b2b_pulse_high", 32'(illegal_pulse), 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("sat_cnt", 32'(illegal_cnt), 32'hFF);
        check("sat_count", 32'(count), 32'd0);

        // Fill with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h022081D7, 32'h100 + 32'(i), 32'h0);
            tick();
        end
        drive(1'b1, 32'h022081D7, 32'h104, 32'h0);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("full_hold_count", 32'(count), 32'd4);
        check("full_hold_head", out_rs1_data, 32'h100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_count", 32'(count), 32'd3);
        check("pop_in_ready", 32'(in_ready), 32'd1);
        check("pop_head", out_rs1_data, 32'h101);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("fifth_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("order", out_rs1_data, 32'h100 + 32'(i));
            tick();
        end
        check("order_drained", 32'(count), 32'd0);

        // Mid-operation reset flushes queued entries
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h9642E457, 32'h200 + 32'(i), 32'h0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_cycle_valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_cnt", 32'(illegal_cnt), 32'd0);
        drive(1'b1, 32'h022081D7, 32'h555, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("post_flush_valid", 32'(out_valid), 32'd1);
        check("post_flush_head", out_rs1_data, 32'h555);
        check("post_flush_count", 32'(count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
